// File: rtl/led_fade_pkg.sv
// -----------------------------------------------------------------------------
// led_fade_pkg
// Shared constants and types for the LED fade stage.
//   LED_ON / LED_OFF : pin levels for the active-low LED outputs
//   PWM_BITS_DEF     : default PWM counter / brightness level width
//   NCH_DEF          : default number of LED channels
//   DIM_BITS         : width of the optional global dim shift amount
//   level_t          : brightness level at the default PWM width
// -----------------------------------------------------------------------------
package led_fade_pkg;

  localparam logic LED_ON  = 1'b0;
  localparam logic LED_OFF = 1'b1;

  localparam int PWM_BITS_DEF = 8;
  localparam int NCH_DEF      = 8;
  localparam int DIM_BITS     = 3;

  typedef logic [PWM_BITS_DEF-1:0] level_t;

endpackage

// File: rtl/led_fade_if.sv
// -----------------------------------------------------------------------------
// led_fade_if
// Groups the pattern input and the LED-side outputs of the fade stage.
//   pat_in     : NCH-bit active-low pattern from the upstream shifter
//   led        : NCH-bit active-low LED pins
//   decay_tick : one-cycle strobe at each decay event
//   dim        : global dim shift (only when LED_FADE_GLOBAL_DIM_EN is defined)
// Modports:
//   master : the pattern source / board side (drives pat_in, dim)
//   slave  : the fade stage itself (drives led, decay_tick)
// Configuration macro: LED_FADE_GLOBAL_DIM_EN
// -----------------------------------------------------------------------------
interface led_fade_if
  import led_fade_pkg::*;
#(
  parameter int NCH = NCH_DEF
);

  logic [NCH-1:0]      pat_in;
  logic [NCH-1:0]      led;
  logic                decay_tick;
`ifdef LED_FADE_GLOBAL_DIM_EN
  logic [DIM_BITS-1:0] dim;
`endif

`ifdef LED_FADE_GLOBAL_DIM_EN
  modport master (
    output pat_in,
    output dim,
    input  led,
    input  decay_tick
  );

  modport slave (
    input  pat_in,
    input  dim,
    output led,
    output decay_tick
  );
`else
  modport master (
    output pat_in,
    input  led,
    input  decay_tick
  );

  modport slave (
    input  pat_in,
    output led,
    output decay_tick
  );
`endif

endinterface

// File: rtl/led_fade_chan.sv
// -----------------------------------------------------------------------------
// led_fade_chan
// One LED channel: holds the brightness level, loads full brightness when the
// pattern bit is lit, decays it by DECAY_STEP per decay tick (saturating at 0)
// and drives a registered PWM output.
// Ports:
//   clk          : system clock
//   rstn         : asynchronous active-low reset
//   pwm_cnt_i    : shared free-running PWM counter
//   decay_tick_i : shared decay strobe (registered in the top)
//   pat_i        : registered pattern bit, active-low (0 = lit)
//   dim_i        : global dim shift (only with LED_FADE_GLOBAL_DIM_EN)
//   led_o        : LED pin, active-low
// Configuration macro: LED_FADE_GLOBAL_DIM_EN
// -----------------------------------------------------------------------------
module led_fade_chan
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int DECAY_STEP = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                decay_tick_i,
  input  logic                pat_i,
`ifdef LED_FADE_GLOBAL_DIM_EN
  input  logic [DIM_BITS-1:0] dim_i,
`endif
  output logic                led_o
);

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
  localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] cmpLevel;
  logic                led_q, led_d;

  // Next brightness level. A lit pattern bit wins over a decay tick arriving
  // in the same cycle, so a light returning mid-fade snaps straight to full.
  // The decrement saturates so a dark channel never wraps back to bright.
  always_comb begin
    level_d = level_q;
    if (pat_i == LED_ON) begin
      level_d = LEVEL_MAX;
    end else if (decay_tick_i) begin
      if (level_q >= STEP) begin
        level_d = level_q - STEP;
      end else begin
        level_d = '0;
      end
    end
  end

  // Compare value for the PWM. With the dim option the level is scaled down
  // by a power of two; dim = 0 leaves it untouched.
`ifdef LED_FADE_GLOBAL_DIM_EN
  assign cmpLevel = level_q >> dim_i;
`else
  assign cmpLevel = level_q;
`endif

  // LED is on while the level exceeds the shared counter; at full level this
  // leaves exactly one dark cycle per PWM period (counter at max).
  always_comb begin
    led_d = LED_OFF;
    if (cmpLevel > pwm_cnt_i) begin
      led_d = LED_ON;
    end
  end

  // Level and output registers; reset clears the trail and turns the LED off.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_q <= '0;
      led_q   <= LED_OFF;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_fade.sv
// -----------------------------------------------------------------------------
// led_fade
// Fading-trail LED driver placed between the rotating active-low pattern
// register and the LED pins. A lit pattern bit drives its LED at full
// brightness; once the bit goes unlit the LED fades linearly to dark.
// Ports:
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   bus  : led_fade_if.slave (pat_in in, led / decay_tick out, optional dim in)
// Parameters:
//   NCH        : number of LED channels
//   PWM_BITS   : PWM counter and brightness level width
//   DECAY_DIV  : clk cycles between decay ticks (>= 2)
//   DECAY_STEP : level decrement per decay tick
// Configuration macro: LED_FADE_GLOBAL_DIM_EN (adds the 3-bit dim input)
// -----------------------------------------------------------------------------
module led_fade
  import led_fade_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int DECAY_DIV  = 65536,
  parameter int DECAY_STEP = 8
) (
  input  logic     clk,
  input  logic     rstn,
  led_fade_if.slave bus
);

  localparam int PRESC_BITS = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PRESC_BITS-1:0] PRESC_LAST = PRESC_BITS'(DECAY_DIV - 1);

  logic [NCH-1:0]        pat_q;
  logic [PWM_BITS-1:0]   pwm_cnt_q;
  logic [PRESC_BITS-1:0] presc_q, presc_d;
  logic                  decay_tick_q, decay_tick_d;
  logic [NCH-1:0]        ledVec;

  // Prescaler wrap and decay strobe. The strobe is registered so it is high
  // for the single cycle after the prescaler sits at its last count.
  always_comb begin
    presc_d      = presc_q + PRESC_BITS'(1);
    decay_tick_d = 1'b0;
    if (presc_q == PRESC_LAST) begin
      presc_d      = '0;
      decay_tick_d = 1'b1;
    end
  end

  // Shared timing state plus the single register stage on the pattern.
  // Reset leaves the pattern all unlit so no channel loads on release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pat_q        <= '1;
      pwm_cnt_q    <= '0;
      presc_q      <= '0;
      decay_tick_q <= 1'b0;
    end else begin
      pat_q        <= bus.pat_in;
      pwm_cnt_q    <= pwm_cnt_q + PWM_BITS'(1);
      presc_q      <= presc_d;
      decay_tick_q <= decay_tick_d;
    end
  end

  // One fade channel per LED; all share the counter, strobe and dim value.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    led_fade_chan #(
      .PWM_BITS   (PWM_BITS),
      .DECAY_STEP (DECAY_STEP)
    ) u_chan (
      .clk          (clk),
      .rstn         (rstn),
      .pwm_cnt_i    (pwm_cnt_q),
      .decay_tick_i (decay_tick_q),
      .pat_i        (pat_q[i]),
`ifdef LED_FADE_GLOBAL_DIM_EN
      .dim_i        (bus.dim),
`endif
      .led_o        (ledVec[i])
    );
  end

  assign bus.led        = ledVec;
  assign bus.decay_tick = decay_tick_q;

endmodule
